// File: rtl/coll_pkg.sv
// Shared types and helpers for the ball-collision pair scheduler.
// Holds the FSM state encoding, default sizing and the pair index map.
package coll_pkg;

    localparam int N_BALLS_DEF = 4;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        COMMIT,
        ADV,
        DONE
    } state_t;

    // Linear index of unordered pair (a,b), a<b, in sweep order.
    function automatic int pair_idx(int a, int b, int n);
        return a * (2 * n - a - 1) / 2 + (b - a - 1);
    endfunction

endpackage

// File: rtl/pair_counter.sv
// Holds the current (a,b) ball pair and steps it through the
// fixed sweep order (0,1),(0,2)..(N-2,N-1).
module pair_counter
    import coll_pkg::*;
#(
    parameter int N_BALLS = N_BALLS_DEF,
    parameter int IDX_W   = $clog2(N_BALLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             adv,
    output logic [IDX_W-1:0] a,
    output logic [IDX_W-1:0] b,
    output logic             is_last
);

    localparam logic [IDX_W-1:0] ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_A = IDX_W'(N_BALLS - 2);
    localparam logic [IDX_W-1:0] LAST_B = IDX_W'(N_BALLS - 1);

    logic [IDX_W-1:0] a_nx;
    logic [IDX_W-1:0] b_nx;

    always_comb begin
        a_nx = a;
        b_nx = b;
        if (b < LAST_B) begin
            b_nx = b + ONE;
        end else if (a < LAST_A) begin
            a_nx = a + ONE;
            b_nx = a_nx + ONE;
        end
    end

    assign is_last = (a == LAST_A) && (b == LAST_B);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a <= '0;
            b <= ONE;
        end else if (load) begin
            a <= '0;
            b <= ONE;
        end else if (adv) begin
            a <= a_nx;
            b <= b_nx;
        end
    end

endmodule

// File: rtl/collision_scheduler.sv
// Sweeps every ball pair once per frame through the shared collision resolver.
// Optional per-pair contact latch: define COLL_CONTACT_LATCH_EN.
module collision_scheduler
    import coll_pkg::*;
#(
    parameter int  N_BALLS   = N_BALLS_DEF,
    parameter int  TIMEOUT   = TIMEOUT_DEF,
    localparam int IDX_W     = $clog2(N_BALLS),
    localparam int NUM_PAIRS = N_BALLS * (N_BALLS - 1) / 2,
    localparam int HC_W      = $clog2(NUM_PAIRS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    output logic [IDX_W-1:0] pair_a,
    output logic [IDX_W-1:0] pair_b,
    output logic             req,
    input  logic             ack,
    input  logic             hit,
    output logic             wb_en,
    output logic             busy,
    output logic             sweep_done,
    output logic [HC_W-1:0]  hit_count,
    output logic             overrun,
    output logic             timeout_err
);

    localparam int              TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);
    localparam logic [HC_W-1:0] HC_MAX = HC_W'(NUM_PAIRS);

    state_t           state;
    state_t           nxt;
    logic [TW-1:0]    wcnt;
    logic             load;
    logic             adv;
    logic             tmo;
    logic             is_last;
    logic             commit_ok;
    logic [IDX_W-1:0] a;
    logic [IDX_W-1:0] b;

    pair_counter #(
        .N_BALLS(N_BALLS),
        .IDX_W  (IDX_W)
    ) u_pairs (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .adv    (adv),
        .a      (a),
        .b      (b),
        .is_last(is_last)
    );

`ifdef COLL_CONTACT_LATCH_EN
    localparam int PI_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;

    logic [NUM_PAIRS-1:0] contact;
    logic [PI_W-1:0]      pidx;

    assign pidx      = PI_W'(pair_idx(int'(a), int'(b), N_BALLS));
    // A pair still overlapping from an earlier frame is not resolved again.
    assign commit_ok = hit && !contact[pidx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            contact <= '0;
        end else if (state == REQ && ack) begin
            contact[pidx] <= hit;
        end
    end
`else
    assign commit_ok = hit;
`endif

    always_comb begin
        nxt  = state;
        load = 1'b0;
        adv  = 1'b0;
        tmo  = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_tick) begin
                    nxt  = REQ;
                    load = 1'b1;
                end
            end
            REQ: begin
                if (ack) begin
                    nxt = commit_ok ? COMMIT : ADV;
                end else if (wcnt == T_LAST) begin
                    nxt = ADV;
                    tmo = 1'b1;
                end
            end
            COMMIT: nxt = ADV;
            ADV: begin
                if (is_last) begin
                    nxt = DONE;
                end else begin
                    nxt = REQ;
                    adv = 1'b1;
                end
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wcnt        <= '0;
            req         <= 1'b0;
            wb_en       <= 1'b0;
            busy        <= 1'b0;
            sweep_done  <= 1'b0;
            hit_count   <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state      <= nxt;
            wcnt       <= (state == REQ) ? wcnt + TW'(1) : '0;
            req        <= (nxt == REQ);
            wb_en      <= (nxt == COMMIT);
            busy       <= (nxt != IDLE);
            sweep_done <= (nxt == DONE);
            if (load) begin
                hit_count <= '0;
            end else if (state == COMMIT && hit_count != HC_MAX) begin
                hit_count <= hit_count + HC_W'(1);
            end
            if (frame_tick && state != IDLE) begin
                overrun <= 1'b1;
            end
            if (tmo) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // Pair index is only meaningful to consumers while a sweep runs.
    assign pair_a = busy ? a : '0;
    assign pair_b = busy ? b : '0;

endmodule

// File: doc/collision_scheduler.md
Name: collision_scheduler

Overview:
- Time-multiplexes the single pairwise ball-collision resolver across all ball pairs once per video frame.
- On each frame tick it sweeps every unordered pair (a,b), a<b, in fixed order.
- For each pair it requests a resolve and, on a reported hit, issues a write-back strobe so the ball-state registers take the resolver's new velocity and direction.
- Sits between the frame timing generator and the collision resolver / ball-state register file.

Parameters:
- N_BALLS, 4, number of balls on the table; must be ≥2.
- TIMEOUT, 16, maximum cycles to wait for resolver ack per pair.
- IDX_W, $clog2(N_BALLS), ball index width (derived).
- NUM_PAIRS, N_BALLS*(N_BALLS-1)/2, pairs per sweep (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse; starts a sweep.
- pair_a  out  IDX_W  lower ball index of current pair.
- pair_b  out  IDX_W  higher ball index of current pair.
- req  out  1  resolve request to resolver.
- ack  in  1  resolver done; hit valid this cycle.
- hit  in  1  pair overlap flag, sampled with ack.
- wb_en  out  1  one-cycle commit of resolver outputs for pair_a/pair_b.
- busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse at end of sweep.
- hit_count  out  $clog2(NUM_PAIRS+1)  commits in current/last sweep.
- overrun  out  1  sticky: frame_tick arrived while busy.
- timeout_err  out  1  sticky: a pair timed out.

Behaviour:
- Reset values: all outputs 0; state IDLE; pair_a=0, pair_b=1 internally; contact latch cleared.
- States: IDLE, REQ, COMMIT, ADV, DONE.
- IDLE:
  - On frame_tick: clear hit_count, load pair (0,1), go to REQ. busy=1 from the next cycle.
- REQ:
  - req=1 as a registered output, held high until the cycle ack=1 is sampled; req=0 the following cycle.
  - ack while req=0 is ignored.
  - On ack with hit=1 → COMMIT; on ack with hit=0 → ADV.
  - Wait counter counts from 0. When it reaches TIMEOUT-1 without ack: set timeout_err, drop req, go to ADV with no commit.
  - ack arriving in the same cycle as the timeout takes priority; no error is set.
- COMMIT:
  - wb_en=1 for exactly one cycle with pair_a/pair_b unchanged.
  - hit_count increments (saturates at NUM_PAIRS).
  - Next state ADV.
- ADV:
  - If pair_b<N_BALLS-1: pair_b++.
  - Else if pair_a<N_BALLS-2: pair_a++, pair_b=pair_a+1 (new value).
  - Else (last pair (N_BALLS-2,N_BALLS-1)) → DONE.
  - Otherwise → REQ.
- DONE:
  - sweep_done=1 for one cycle, busy=0 from the next cycle, → IDLE.
- Pair order for N_BALLS=4: (0,1),(0,2),(0,3),(1,2),(1,3),(2,3).
- Minimum per-pair latency: REQ → ack next cycle → COMMIT → ADV = 3–4 cycles.
- frame_tick while not IDLE:
  - Ignored; sets overrun (sticky until rst).
  - frame_tick in the same cycle as DONE is also ignored and sets overrun.
- pair_a/pair_b stay stable while req=1 and during wb_en.
- Reset mid-sweep aborts immediately: req and wb_en drop asynchronously and no partial commit is issued.

Optional Feature:
- Macro: COLL_CONTACT_LATCH_EN.
- Enabled:
  - NUM_PAIRS-bit contact latch, one bit per pair index.
  - On ack with hit=1 and the latch bit set: no COMMIT, go to ADV.
  - On ack with hit=1 and the latch bit clear: COMMIT and set the bit.
  - On ack with hit=0: clear the bit.
  - Purpose: prevents re-resolving balls that are still overlapping across consecutive frames.
- Disabled:
  - Every hit commits; no latch storage.

Decomposition:
- Shared package coll_pkg holds:
  - state enum (IDLE, REQ, COMMIT, ADV, DONE);
  - default N_BALLS and TIMEOUT constants;
  - pair-index function pair_idx(a,b) used by the contact latch.
- One natural sub-module: pair_counter. It holds the (a,b) register and produces next-pair and is_last.
- The FSM, timeout counter and latch stay in the top module.

Test Plan:
- N_BALLS=4, resolver acks 1 cycle after req with hit=0 always → 6 REQ handshakes in order (0,1)..(2,3); zero wb_en; one sweep_done; hit_count=0.
- Same stimulus but hit=1 only on pair (1,3) → exactly one wb_en, with pair_a=1, pair_b=3; hit_count=1.
- Resolver never acks on pair (0,2), TIMEOUT=16 → req high for 16 cycles then low; timeout_err=1; no wb_en; sweep continues to (0,3) and completes.
- frame_tick pulsed again 5 cycles into a sweep → overrun=1; pair sequence unaffected; exactly one sweep_done.
- With COLL_CONTACT_LATCH_EN, pair (0,1) hit=1 on frames 1 and 2, hit=0 on frame 3, hit=1 on frame 4 → wb_en for (0,1) on frames 1 and 4 only.
- Assert rst while in REQ for pair (1,2) → req=0 and busy=0 immediately; the next frame_tick restarts at (0,1).
